// File: rtl/load_store_unit.sv
// load_store_unit: sequences register-file loads/stores through a req/ack data-memory handshake.
// Ports: clk, rst_n (async active-low); ls_start/ls_store/ls_reg_sel/ls_addr/ls_wdata command in;
// busy/done/err status out; mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata memory side;
// mem_load/reg_sel/write_data register-file write port. Define LSU_TIMEOUT_EN to abort REQ after TIMEOUT cycles.
module load_store_unit #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ls_start,
  input  logic              ls_store,
  input  logic [2:0]        ls_reg_sel,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [15:0]       ls_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              mem_load,
  output logic [2:0]        reg_sel,
  output logic [15:0]       write_data
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic       is_store;
  assign busy = state != IDLE;
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  // an ack on the expiry edge takes priority over the abort
  wire tmo = !mem_ack && cnt == CW'(TIMEOUT - 1);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_store   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_load   <= 1'b0;
      reg_sel    <= '0;
      write_data <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: if (ls_start) begin
          state     <= REQ;
          is_store  <= ls_store;
          mem_req   <= 1'b1;
          mem_we    <= ls_store;
          mem_addr  <= ls_addr;
          mem_wdata <= ls_wdata;
          reg_sel   <= ls_reg_sel;
`ifdef LSU_TIMEOUT_EN
          cnt       <= '0;
`endif
        end
        REQ: if (mem_ack) begin
          state    <= RESP;
          mem_req  <= 1'b0;
          mem_we   <= 1'b0;
          done     <= 1'b1;
          mem_load <= !is_store;
          if (!is_store) write_data <= mem_rdata;
        end
`ifdef LSU_TIMEOUT_EN
        else if (tmo) begin
          state   <= RESP;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          done    <= 1'b1;
          err     <= 1'b1;
        end else cnt <= cnt + 1'b1;
`endif
        RESP: begin
          state    <= IDLE;
          mem_load <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench with a behavioural memory model for load_store_unit.
module tb_load_store_unit;
  localparam int TMO = 4;
  typedef struct {logic [15:0] a; logic we; logic [15:0] d; int lat;} req_t;
  typedef struct {logic ld; logic [2:0] sel; logic [15:0] d; logic er;} rsp_t;
  logic clk = 0, rst_n = 0;
  logic ls_start = 0, ls_store = 0;
  logic [2:0] ls_reg_sel = 0;
  logic [15:0] ls_addr = 0, ls_wdata = 0;
  logic busy, done, err, mem_req, mem_we, mem_load;
  logic [15:0] mem_addr, mem_wdata, write_data;
  logic [2:0] reg_sel;
  logic mem_ack = 0;
  logic [15:0] mem_rdata = 0;
  int tests = 0, fails = 0;
  req_t req_q[$];
  rsp_t resp_q[$];
  logic [15:0] ref_mem [16];
  logic [15:0] mem_resp [16];
  req_t cur;
  logic in_req = 0, prev_done = 0;
  int cyc = 0, want = 0;

  load_store_unit #(.ADDR_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ls_start(ls_start), .ls_store(ls_store), .ls_reg_sel(ls_reg_sel),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_load(mem_load), .reg_sel(reg_sel),
    .write_data(write_data));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // issue one command; lat = wait cycles before ack (negative picks a random 0..3)
  task automatic issue(input logic st, input logic [2:0] sel, input logic [15:0] a,
                       input logic [15:0] d, input int lat, input logic exp_err);
    int n = 0;
    int l = lat < 0 ? int'($urandom_range(0, 3)) : lat;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 0);
    req_q.push_back('{a: a, we: st, d: d, lat: l});
    resp_q.push_back('{ld: !st, sel: sel, d: st ? 16'h0 : ref_mem[a[3:0]], er: exp_err});
    if (st && !exp_err) ref_mem[a[3:0]] = d;
    ls_start = 1; ls_store = st; ls_reg_sel = sel; ls_addr = a; ls_wdata = d;
    @(posedge clk); #1;
    ls_start = 0; ls_addr = 16'($urandom); ls_wdata = 16'($urandom);
  endtask

  // memory responder: checks request fields, applies latency, stores/returns data
  always @(negedge clk) begin : responder
    if (!rst_n) begin
      in_req = 0;
      mem_ack = 0;
    end else begin
      mem_ack = 0;
      mem_rdata = 16'($urandom);
      if (mem_req) begin
        if (!in_req) begin
          in_req = 1;
          cyc = 0;
          if (req_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_req: mem_addr=%0h with none expected", mem_addr);
            cur = '{a: mem_addr, we: mem_we, d: mem_wdata, lat: 0};
          end else cur = req_q.pop_front();
          want = cur.lat + 1;
`ifdef LSU_TIMEOUT_EN
          if (want > TMO) want = TMO;
`endif
        end
        cyc++;
        chk("mem_addr", 32'(mem_addr), 32'(cur.a));
        chk("mem_we", 32'(mem_we), 32'(cur.we));
        if (cur.we) chk("mem_wdata", 32'(mem_wdata), 32'(cur.d));
        if (cyc == cur.lat + 1) begin
          mem_ack = 1;
          if (cur.we) mem_resp[cur.a[3:0]] = cur.d;
          else mem_rdata = mem_resp[cur.a[3:0]];
        end
      end else if (in_req) begin
        in_req = 0;
        chk("req_cycles", 32'(cyc), 32'(want));
      end
    end
  end

  // completion monitor
  always @(negedge clk) begin : monitor
    rsp_t r;
    if (!rst_n) prev_done = 0;
    else begin
      if (prev_done) chk("busy_after_done", 32'(busy), 0);
      if (done) begin
        if (resp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: reg_sel=%0d with none expected", reg_sel);
        end else begin
          r = resp_q.pop_front();
          chk("mem_load", 32'(mem_load), 32'(r.ld && !r.er));
          if (r.ld && !r.er) chk("write_data", 32'(write_data), 32'(r.d));
          chk("reg_sel", 32'(reg_sel), 32'(r.sel));
          chk("err", 32'(err), 32'(r.er));
          chk("req_low_at_done", 32'(mem_req), 0);
          chk("busy_at_done", 32'(busy), 1);
        end
      end else begin
        chk("load_only_with_done", 32'(mem_load), 0);
        chk("err_only_with_done", 32'(err), 0);
      end
      prev_done = done;
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 16'(i * 16'h1111) ^ 16'hA5A5;
      mem_resp[i] = 16'(i * 16'h1111) ^ 16'hA5A5;
    end
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_load", 32'(mem_load), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_write_data", 32'(write_data), 0);
    chk("rst_reg_sel", 32'(reg_sel), 0);
    #20;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    ref_mem[0] = 16'hBEEF;
    mem_resp[0] = 16'hBEEF;
    issue(0, 3'd3, 16'h0040, 16'h0, 1, 0);
    issue(1, 3'd5, 16'h0012, 16'h1234, 0, 0);
    issue(0, 3'd1, 16'h0007, 16'h0, 2, 0);
    ls_start = 1; ls_store = 1; ls_addr = 16'h0099;
    @(posedge clk); #1;
    ls_start = 0;
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_resp", 32'(done), 1);
    ls_start = 1; ls_addr = 16'h0055;
    @(posedge clk); #1;
    ls_start = 0;
    issue(0, 3'd2, 16'h0003, 16'h0, 100, 0);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_mem_load", 32'(mem_load), 0);
    chk("arst_done", 32'(done), 0);
    req_q.delete();
    resp_q.delete();
    @(posedge clk); #1;
    rst_n = 1;
    issue(0, 3'd6, 16'h0003, 16'h0, 0, 0);
`ifdef LSU_TIMEOUT_EN
    issue(0, 3'd4, 16'h0021, 16'h0, 100, 1);
    issue(0, 3'd4, 16'h0022, 16'h0, TMO - 1, 0);
`endif
    for (int i = 0; i < 40; i++)
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), -1, 0);
    n = 0;
    while ((busy || resp_q.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_resp_q", 32'(resp_q.size()), 0);
    chk("drain_idle", 32'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
